// File: rtl/div_iter_if.sv
// div_iter_if: request/result bundle between the execute stage and the iterative divider.
interface div_iter_if #(parameter int WIDTH = 32);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             ready;
    modport master (output start, sign, a, b, input q, r, busy, ready);
    modport slave  (input start, sign, a, b, output q, r, busy, ready);
endinterface

// File: rtl/div_iter.sv
// div_iter: restoring divider for DIV/DIVU/REM/REMU, one trial subtraction per clock.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish without iterating.
module div_iter #(parameter int WIDTH = 32) (
    input  logic      clk,
    input  logic      rst,
    div_iter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_qneg;
    logic             r_rneg;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_last;
    logic             w_bz;

    assign w_abs_a = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_abs_b = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign w_bz    = (bus.b == '0);

    // r_quo doubles as the dividend shift register; its MSB feeds the partial remainder
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_ge      = w_shift[WIDTH] | ~w_diff[WIDTH];
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
    logic w_ovf;
    assign w_ovf = bus.sign && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
        end else if (r_state == CALC) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_state <= DONE;
                r_q     <= r_qneg ? -w_quo_nxt : w_quo_nxt;
                r_r     <= r_rneg ? -w_rem_nxt : w_rem_nxt;
            end
        end else if (bus.start) begin
            r_state <= CALC;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_div   <= w_abs_b;
            // quotient of x/0 stays all ones, so its sign fixup is suppressed
            r_qneg  <= bus.sign && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) && !w_bz;
            r_rneg  <= bus.sign && bus.a[WIDTH-1];
`ifdef DIV_EARLY_OUT_EN
            if (w_bz || w_ovf) begin
                r_state <= DONE;
                r_q     <= w_bz ? '1 : bus.a;
                r_r     <= w_bz ? bus.a : '0;
            end
`endif
        end else begin
            r_state <= IDLE;
        end
    end

    assign bus.q     = r_q;
    assign bus.r     = r_r;
    assign bus.busy  = (r_state == CALC);
    assign bus.ready = (r_state == DONE);
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and randomized checks of div_iter against an arithmetic reference.
module tb_div_iter;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    div_iter_if #(.WIDTH(W)) bus();
    div_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int ref_lat(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == '0 || (s && a == 32'h8000_0000 && b == '1)) return 1;
`endif
        return W + 1;
    endfunction

    task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output int lat, output int nbusy, output logic busy_rdy);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sign = s;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.sign = 1'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
        lat = 0;
        nbusy = 0;
        for (int n = 1; n <= 200; n++) begin
            if (bus.busy) nbusy++;
            if (bus.ready) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        q = bus.q;
        r = bus.r;
        busy_rdy = bus.busy;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.sign = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.q, bus.r, bus.busy, bus.ready} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got q=%h r=%h busy=%b ready=%b exp all 0", bus.q, bus.r, bus.busy, bus.ready);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.busy, bus.ready} !== 2'b00) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b ready=%b exp 0 0", bus.busy, bus.ready);
        end
    endtask

    task automatic test_unsigned();
        logic [W-1:0] q, r;
        int lat, nb;
        logic br;
        run_op(1'b0, 32'd100, 32'd7, q, r, lat, nb, br);
        total++;
        if (q !== 32'd14 || r !== 32'd2) begin
            bad++;
            $display("FAIL unsigned_100_7 got q=%0d r=%0d exp q=14 r=2", q, r);
        end
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL unsigned_latency got %0d exp 33", lat);
        end
        total++;
        if (nb !== 32 || br !== 1'b0) begin
            bad++;
            $display("FAIL unsigned_busy got cycles=%0d busy_at_ready=%b exp 32 0", nb, br);
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] q, r;
        int lat, nb;
        logic br;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, lat, nb, br);
        total++;
        if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL signed_m7_2 got q=%h r=%h exp q=fffffffd r=ffffffff", q, r);
        end
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, q, r, lat, nb, br);
        total++;
        if (q !== 32'h7FFF_FFFC || r !== 32'd1) begin
            bad++;
            $display("FAIL unsigned_big_2 got q=%h r=%h exp q=7ffffffc r=1", q, r);
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r, eq, er;
        int lat, nb;
        logic br;
        for (int i = 0; i < 3; i++) begin
            logic [W-1:0] a = (i == 2) ? 32'hFFFF_FFFB : 32'd5;
            bit s = (i != 0);
            run_op(s, a, '0, q, r, lat, nb, br);
            ref_div(s, a, '0, eq, er);
            total++;
            if (q !== eq || r !== er) begin
                bad++;
                $display("FAIL div_zero_%0d got q=%h r=%h exp q=%h r=%h", i, q, r, eq, er);
            end
            total++;
            if (lat !== ref_lat(s, a, '0) || nb !== lat - 1) begin
                bad++;
                $display("FAIL div_zero_timing_%0d got lat=%0d busy=%0d exp lat=%0d", i, lat, nb, ref_lat(s, a, '0));
            end
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] q, r;
        int lat, nb;
        logic br;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, lat, nb, br);
        total++;
        if (q !== 32'h8000_0000 || r !== 32'd0) begin
            bad++;
            $display("FAIL overflow got q=%h r=%h exp q=80000000 r=0", q, r);
        end
        total++;
        if (lat !== ref_lat(1'b1, 32'h8000_0000, 32'hFFFF_FFFF) || nb !== lat - 1) begin
            bad++;
            $display("FAIL overflow_timing got lat=%0d busy=%0d", lat, nb);
        end
    endtask

    task automatic test_back_to_back();
        int n, m;
        logic [W-1:0] held;
        @(negedge clk);
        bus.start = 1'b1;
        bus.sign = 1'b0;
        bus.a = 32'd100;
        bus.b = 32'd7;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            bus.start = (k == 10);
            if (k == 10) begin
                bus.a = 32'd9;
                bus.b = 32'd3;
            end
            if (bus.ready) begin
                n = k;
                break;
            end
        end
        total++;
        if (n !== 33 || bus.q !== 32'd14 || bus.r !== 32'd2) begin
            bad++;
            $display("FAIL ignore_busy_start got lat=%0d q=%0d r=%0d exp 33 14 2", n, bus.q, bus.r);
        end
        bus.start = 1'b1;
        bus.sign = 1'b0;
        bus.a = 32'd9;
        bus.b = 32'd3;
        m = 0;
        held = '0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a = $urandom;
            if (k == 5) held = bus.q;
            if (bus.ready) begin
                m = k;
                break;
            end
        end
        total++;
        if (held !== 32'd14) begin
            bad++;
            $display("FAIL result_hold got q=%0d exp 14", held);
        end
        total++;
        if (m !== 33 || bus.q !== 32'd3 || bus.r !== 32'd0) begin
            bad++;
            $display("FAIL back_to_back got lat=%0d q=%0d r=%0d exp 33 3 0", m, bus.q, bus.r);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] q, r;
        int lat, nb, seen;
        logic br;
        @(negedge clk);
        bus.start = 1'b1;
        bus.sign = 1'b0;
        bus.a = 32'd1000;
        bus.b = 32'd3;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.q, bus.r, bus.busy, bus.ready} !== '0) begin
            bad++;
            $display("FAIL reset_mid got q=%h r=%h busy=%b ready=%b exp all 0", bus.q, bus.r, bus.busy, bus.ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready || bus.busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_no_ready got %0d active cycles exp 0", seen);
        end
        run_op(1'b0, 32'd100, 32'd7, q, r, lat, nb, br);
        total++;
        if (q !== 32'd14 || r !== 32'd2 || lat !== 33) begin
            bad++;
            $display("FAIL after_reset got q=%0d r=%0d lat=%0d exp 14 2 33", q, r, lat);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        int lat, nb;
        logic br;
        bit s;
        for (int i = 0; i < 150; i++) begin
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                1: b = W'($urandom_range(0, 15));
                2: b = {{(W-4){b[W-1]}}, b[3:0]};
                3: a = W'($urandom_range(0, 50));
                4: begin
                    a = 32'h8000_0000;
                    b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'd0;
                end
                default: ;
            endcase
            run_op(s, a, b, q, r, lat, nb, br);
            ref_div(s, a, b, eq, er);
            total++;
            if (q !== eq || r !== er || lat !== ref_lat(s, a, b) || nb !== lat - 1 || br !== 1'b0) begin
                bad++;
                $display("FAIL random_%0d s=%b a=%h b=%h got q=%h r=%h lat=%0d busy=%0d exp q=%h r=%h lat=%0d",
                         i, s, a, b, q, r, lat, nb, eq, er, ref_lat(s, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative restoring integer divider for the RISC-V M-extension path (DIV, DIVU, REM, REMU). It is the subtract-side counterpart of the carry-generate/propagate adder cells: one trial subtraction per clock, WIDTH iterations per operation. It sits beside the pipeline's execute stage. The pipeline stalls on `busy` and captures results on the `ready` pulse.

## Interface
- `WIDTH`, default 32: operand and result width in bits.
- `clk`  in  1: clock; all state changes on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a division; sampled only when `busy`=0.
- `sign`  in  1: 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); latched with `start`.
- `a`  in  WIDTH: dividend; latched with `start`.
- `b`  in  WIDTH: divisor; latched with `start`.
- `q`  out  WIDTH: quotient; registered.
- `r`  out  WIDTH: remainder; registered.
- `busy`  out  1: iteration in progress.
- `ready`  out  1: one-cycle pulse; `q` and `r` are valid from this cycle.

## Operation
- Reset value of every output is 0: `q`, `r`, `busy`, `ready`. The FSM resets to IDLE.
- States:
  - IDLE → CALC on `start`.
  - CALC → DONE when the iteration counter reaches WIDTH-1.
  - DONE → IDLE unconditionally, or DONE → CALC if `start` is high in DONE.
- At `start`:
  - If `sign`=1, latch magnitudes |a| and |b| and record the result signs.
  - Quotient sign is a[MSB]^b[MSB]. Remainder sign is a[MSB].
  - The counter clears to 0.
- Each CALC cycle:
  - The partial remainder shifts left one bit, taking in the next dividend bit from the MSB.
  - Trial-subtract |b| in a (WIDTH+1)-bit subtractor.
  - If the result is non-negative, keep it and shift in quotient bit 1. Otherwise restore and shift in 0.
- DONE:
  - Negate the quotient and/or remainder per the recorded signs.
  - Write `q` and `r`. Assert `ready` for exactly this cycle.
- Divide by zero (b=0), any `sign`: `q` = all ones, `r` = a.
- Signed overflow (a = 1 followed by WIDTH-1 zeros, b = all ones, `sign`=1): `q` = a, `r` = 0.
- The restoring algorithm yields both special-case results naturally once sign fixup is skipped for b=0. No special datapath is needed unless the early-out macro is set.
- `q` and `r` hold their values until the next DONE or reset. Operand changes after `start` have no effect.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high with `busy`=0.
- `busy` is high in cycles 1..WIDTH.
- `ready` is high in cycle WIDTH+1, with `busy`=0 in that cycle. Latency is WIDTH+1, i.e. 33 for WIDTH=32.
- A `start` raised in the `ready` cycle is accepted, giving back-to-back operation with no gap.
- `start` while `busy`=1 is ignored; there is no queueing.
- `rst` asserted mid-operation:
  - Outputs clear to 0 immediately; no `ready` pulse occurs.
  - After `rst` deasserts, the next `start` behaves as from cold.

## Configuration
- Macro `DIV_EARLY_OUT_EN`.
- Defined: divide-by-zero and signed-overflow operations skip CALC. The FSM goes IDLE → DONE directly, and `ready` is asserted in cycle 1 with `busy` never rising. All other operations are unchanged.
- Undefined: every operation takes WIDTH+1 cycles. Results are bit-identical to the defined case.

## Test plan
- Unsigned, WIDTH=32: `sign`=0, a=100, b=7 → `ready` in cycle 33, q=14, r=2, `busy` high in cycles 1..32 only.
- Signed negative dividend: `sign`=1, a=0xFFFFFFF9 (-7), b=2 → q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
- Divide by zero: a=5, b=0, either sign → q=0xFFFFFFFF, r=5. `ready` in cycle 33 without the macro, cycle 1 with `DIV_EARLY_OUT_EN`.
- Signed overflow: `sign`=1, a=0x80000000, b=0xFFFFFFFF → q=0x80000000, r=0.
- Handshake:
  - A second `start` (a=9, b=3) at cycle 10 of an active op is ignored; the first result is unchanged.
  - The same `start` raised in the `ready` cycle is accepted → q=3, r=0 exactly 33 cycles later.
- Reset mid-op: `rst` pulsed at cycle 15 → all outputs 0 immediately, no `ready` pulse. A subsequent 100/7 `start` returns q=14, r=2.
